// File: rtl/ifu_fetch.sv
// ============================================================================
//  Module   : ifu_fetch
//  Purpose  : Instruction fetch stage. Owns the PC, issues one imem read at a
//             time, buffers the returned word and hands it to the decoder.
//             Redirects flush wrong-path fetches (at most one in flight).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
  parameter int                   CPU_WIDTH = 32,
  parameter int                   INS_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_imem_req_valid,
  input  logic                 i_imem_req_ready,
  output logic [CPU_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_rsp_valid,
  input  logic [INS_WIDTH-1:0] i_imem_rsp_data,
  input  logic                 i_imem_rsp_err,
  input  logic                 i_redirect,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc,
  output logic                 o_ins_valid,
  input  logic                 i_ins_ready,
  output logic [INS_WIDTH-1:0] o_ins,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic                 o_ins_err
);

  // S_REQ: request on the bus; S_WAIT: one read outstanding; S_HOLD: word
  // presented to the decoder.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [CPU_WIDTH-1:0]   pc, pc_nx;
  logic                   drop, drop_nx;
  logic [INS_WIDTH-1:0]   ins_q, ins_nx;
  logic [CPU_WIDTH-1:0]   ins_pc_q, ins_pc_nx;
  logic                   ins_err_q, ins_err_nx;
  logic [CPU_WIDTH-1:0]   target;
  logic                   unused_redirect_lo;

  // Misaligned redirect targets are forced to word alignment; the PC unit
  // is responsible for raising the alignment fault.
  assign target             = {i_redirect_pc[CPU_WIDTH-1:2], 2'b00};
  assign unused_redirect_lo = ^i_redirect_pc[1:0];

  assign o_imem_req_valid = (state == S_REQ) & i_rst_n;
  assign o_imem_addr      = {pc[CPU_WIDTH-1:2], 2'b00};
  assign o_ins_valid      = (state == S_HOLD);
  assign o_ins            = ins_q;
  assign o_pc             = ins_pc_q;
  assign o_ins_err        = ins_err_q;

  // State register and datapath registers, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      ins_q     <= '0;
      ins_pc_q  <= RESET_PC;
      ins_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      drop      <= drop_nx;
      ins_q     <= ins_nx;
      ins_pc_q  <= ins_pc_nx;
      ins_err_q <= ins_err_nx;
    end
  end

  // Next-state and next-datapath logic; everything holds by default.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    drop_nx    = drop;
    ins_nx     = ins_q;
    ins_pc_nx  = ins_pc_q;
    ins_err_nx = ins_err_q;
    case (state)
      S_REQ: begin
        if (i_imem_req_ready) begin
          state_nx = S_WAIT;
          // Request already accepted: its response is now wrong-path.
          if (i_redirect) begin
            pc_nx   = target;
            drop_nx = 1'b1;
          end
        end else if (i_redirect) begin
          // Nothing accepted yet, so the address may simply change.
          pc_nx = target;
        end
      end
      S_WAIT: begin
        if (i_imem_rsp_valid) begin
          if (drop || i_redirect) begin
            drop_nx  = 1'b0;
            state_nx = S_REQ;
            if (i_redirect) pc_nx = target;
          end else begin
            ins_nx     = i_imem_rsp_data;
            ins_pc_nx  = pc;
            ins_err_nx = i_imem_rsp_err;
            pc_nx      = pc + CPU_WIDTH'(4);
            state_nx   = S_HOLD;
          end
        end else if (i_redirect) begin
          pc_nx   = target;
          drop_nx = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect wins over the decoder handshake and flushes the word.
        if (i_redirect) begin
          pc_nx    = target;
          state_nx = S_REQ;
        end else if (i_ins_ready) begin
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_REQ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
//  Module   : tb_ifu_fetch
//  Purpose  : Self-checking bench for ifu_fetch: transaction-level reference
//             model, memory responder, directed scenarios plus random run.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        i_rst_n;
  logic        i_imem_req_ready;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_imem_rsp_err;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_ins_ready;
  logic        o_imem_req_valid;
  logic [31:0] o_imem_addr;
  logic        o_ins_valid;
  logic [31:0] o_ins;
  logic [31:0] o_pc;
  logic        o_ins_err;

  ifu_fetch #(.CPU_WIDTH(32), .INS_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .i_clk            (clk),
    .i_rst_n          (i_rst_n),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_imem_rsp_err   (i_imem_rsp_err),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_ins_valid      (o_ins_valid),
    .i_ins_ready      (i_ins_ready),
    .o_ins            (o_ins),
    .o_pc             (o_pc),
    .o_ins_err        (o_ins_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cycle    = 0;

  // Stimulus knobs
  int p_req_ready = 100, p_ins_ready = 100, p_redir = 0, lat_fixed = 0;
  bit nop_mode = 1, poison = 0, err_mode = 0, rand_rst = 0;
  bit force_rst = 0, force_redir = 0;
  int force_rdy = -1;
  logic [31:0] force_pc = '0;

  // Reference model: in-flight read, held word, next fetch address
  bit          m_out = 0, m_doom = 0, m_held = 0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0, m_nf = RST_PC;
  logic [31:0] m_ins = '0, m_pc = RST_PC;
  bit          m_err = 0;

  // Log of words the DUT handed to the decoder
  logic [31:0] dl_pc[$], dl_ins[$];
  bit          dl_err[$];
  int          dl_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (poison && a == RST_PC) return 32'hDEAD_BEEF;
    if (nop_mode) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit mem_err(input logic [31:0] a);
    if (err_mode) return (a == RST_PC + 32'd4);
    if (nop_mode) return 1'b0;
    return ((a >> 2) % 7) == 3;
  endfunction

  task automatic check_all();
    bit exp_req;
    exp_req = i_rst_n && !m_out && !m_held;
    chk("ins_valid", {31'b0, o_ins_valid}, {31'b0, m_held});
    chk("req_valid", {31'b0, o_imem_req_valid}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", o_imem_addr, m_nf);
    chk("o_pc", o_pc, m_pc);
    chk("o_ins", o_ins, m_ins);
    chk("o_ins_err", {31'b0, o_ins_err}, {31'b0, m_err});
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic cyc();
    bit rstn, red, rdy, rrdy, rv;
    logic [31:0] rpc, tgt;
    rstn = !(force_rst || (rand_rst && $urandom_range(0, 299) == 0));
    red  = force_redir || ($urandom_range(0, 99) < p_redir);
    case ($urandom_range(0, 9))
      0:       rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      1:       rpc = $urandom;
      default: rpc = RST_PC + $urandom_range(0, 255);
    endcase
    if (force_redir) rpc = force_pc;
    rdy  = (force_rdy >= 0) ? (force_rdy != 0) : ($urandom_range(0, 99) < p_ins_ready);
    rrdy = $urandom_range(0, 99) < p_req_ready;
    rv   = m_out && (m_cnt == 0);

    i_rst_n          = rstn;
    i_redirect       = red;
    i_redirect_pc    = rpc;
    i_ins_ready      = rdy;
    i_imem_req_ready = rrdy;
    i_imem_rsp_valid = rv;
    i_imem_rsp_data  = rv ? mem_data(m_addr) : $urandom;
    i_imem_rsp_err   = rv ? mem_err(m_addr) : 1'b0;
    #1;
    if (o_ins_valid && rdy && !red && rstn) begin
      dl_pc.push_back(o_pc); dl_ins.push_back(o_ins);
      dl_err.push_back(o_ins_err); dl_cyc.push_back(cycle);
    end

    tgt = {rpc[31:2], 2'b00};
    if (!rstn) begin
      m_out = 0; m_doom = 0; m_held = 0; m_nf = RST_PC;
      m_ins = '0; m_pc = RST_PC; m_err = 0;
    end else begin
      if (m_held) begin
        if (red || rdy) m_held = 0;
      end else if (m_out) begin
        if (rv) begin
          m_out = 0;
          if (!(m_doom || red)) begin
            m_held = 1; m_ins = mem_data(m_addr); m_pc = m_addr;
            m_err = mem_err(m_addr); m_nf = m_addr + 32'd4;
          end
        end else begin
          m_cnt--;
          if (red) m_doom = 1;
        end
      end else if (rrdy) begin
        m_out = 1; m_addr = m_nf; m_doom = red;
        m_cnt = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
      end
      if (red) m_nf = tgt;
    end

    force_rst = 0; force_redir = 0; force_rdy = -1;
    @(posedge clk);
    @(negedge clk);
    cycle++;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    force_rst = 1; cyc();
    force_rst = 1; cyc();
    dl_pc.delete(); dl_ins.delete(); dl_err.delete(); dl_cyc.delete();
  endtask

  // what: 0 read outstanding, 1 word held, 2 DUT requesting, 3 delivery logged
  task automatic wait_for(input int what, input int budget, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      cyc();
      case (what)
        0: hit = m_out;
        1: hit = m_held;
        2: hit = o_imem_req_valid;
        default: hit = dl_pc.size() > 0;
      endcase
    end
    chk({"wait_", name}, {31'b0, hit}, 32'd1);
  endtask

  initial begin
    bit seen;
    i_rst_n = 0; i_imem_req_ready = 0; i_imem_rsp_valid = 0; i_imem_rsp_data = '0;
    i_imem_rsp_err = 0; i_redirect = 0; i_redirect_pc = '0; i_ins_ready = 0;
    @(negedge clk);

    // Reset state and zero-wait streaming
    do_reset();
    chk("rst_ins_valid", {31'b0, o_ins_valid}, 32'd0);
    chk("rst_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
    chk("rst_o_pc", o_pc, 32'h8000_0000);
    chk("rst_o_ins", o_ins, 32'h0);
    chk("rst_o_err", {31'b0, o_ins_err}, 32'd0);
    run(10);
    chk("stream_count", dl_pc.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
    if (dl_pc.size() >= 3) begin
      chk("stream_pc0", dl_pc[0], 32'h8000_0000);
      chk("stream_pc1", dl_pc[1], 32'h8000_0004);
      chk("stream_pc2", dl_pc[2], 32'h8000_0008);
      chk("stream_ins1", dl_ins[1], 32'h0000_0013);
      chk("stream_gap1", dl_cyc[1] - dl_cyc[0], 32'd3);
      chk("stream_gap2", dl_cyc[2] - dl_cyc[1], 32'd3);
    end

    // Memory stalls the request
    do_reset();
    p_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
      chk("stall_addr", o_imem_addr, 32'h8000_0000);
      chk("stall_no_ins", {31'b0, o_ins_valid}, 32'd0);
    end
    p_req_ready = 100;
    wait_for(3, 10, "stall_delivery");
    if (dl_pc.size() > 0) chk("stall_pc", dl_pc[0], 32'h8000_0000);

    // Decoder back-pressure
    p_ins_ready = 0;
    wait_for(1, 10, "held");
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_pc", o_pc, 32'h8000_0004);
      chk("bp_valid", {31'b0, o_ins_valid}, 32'd1);
      chk("bp_no_req", {31'b0, o_imem_req_valid}, 32'd0);
    end
    p_ins_ready = 100;
    wait_for(2, 10, "bp_next_req");
    chk("bp_next_addr", o_imem_addr, 32'h8000_0008);

    // Redirect during S_WAIT discards the poisoned response
    poison = 1; lat_fixed = 2;
    do_reset();
    wait_for(0, 10, "redir_wait");
    force_redir = 1; force_pc = 32'h8000_0103;
    cyc();
    run(15);
    seen = 0;
    foreach (dl_ins[i]) if (dl_ins[i] == 32'hDEAD_BEEF) seen = 1;
    chk("no_deadbeef", {31'b0, seen}, 32'd0);
    if (dl_pc.size() > 0) chk("redir_pc", dl_pc[0], 32'h8000_0100);
    else chk("redir_delivery", 32'd0, 32'd1);
    poison = 0; lat_fixed = 0;

    // Redirect in S_HOLD beats decoder ready
    do_reset();
    wait_for(1, 10, "hold");
    force_redir = 1; force_pc = 32'h8000_0200; force_rdy = 1;
    cyc();
    chk("flush_valid", {31'b0, o_ins_valid}, 32'd0);
    chk("flush_req", {31'b0, o_imem_req_valid}, 32'd1);
    chk("flush_addr", o_imem_addr, 32'h8000_0200);

    // Access fault travels with the instruction
    err_mode = 1;
    do_reset();
    run(10);
    if (dl_pc.size() >= 3) begin
      chk("err_pc1", dl_pc[1], 32'h8000_0004);
      chk("err_flag1", {31'b0, dl_err[1]}, 32'd1);
      chk("err_pc2", dl_pc[2], 32'h8000_0008);
      chk("err_flag2", {31'b0, dl_err[2]}, 32'd0);
    end else chk("err_count", 32'd0, 32'd1);
    err_mode = 0;

    // Reset while a read is outstanding
    lat_fixed = 2;
    do_reset();
    wait_for(0, 10, "rst_wait");
    force_rst = 1; cyc();
    chk("midrst_valid", {31'b0, o_ins_valid}, 32'd0);
    p_req_ready = 0;
    cyc();
    chk("midrst_req", {31'b0, o_imem_req_valid}, 32'd1);
    chk("midrst_addr", o_imem_addr, 32'h8000_0000);

    // Randomized run
    nop_mode = 0; lat_fixed = -1; p_req_ready = 70; p_ins_ready = 70;
    p_redir = 10; rand_rst = 1;
    do_reset();
    run(4000);
    chk("random_progress", dl_pc.size() > 100 ? 32'd1 : 32'd0, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage directly upstream of the decoder.
- Owns the architectural PC.
- Issues one instruction-memory read at a time over a valid/ready request channel and accepts the response on a valid-only channel.
- Buffers the fetched word and presents it, with its PC, to the decoder over a valid/ready handshake.
- Accepts redirects (jal/jalr/branch/ecall/mret target) from the PC unit and discards wrong-path fetches.

Parameters:
CPU_WIDTH, 32, PC/address width
INS_WIDTH, 32, instruction width
RESET_PC, 32'h8000_0000, PC value loaded on reset

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  reset, synchronous, active-low
o_imem_req_valid  out  1  fetch request valid
i_imem_req_ready  in  1  memory accepts request
o_imem_addr  out  CPU_WIDTH  fetch address; bits[1:0] always 0
i_imem_rsp_valid  in  1  response data valid; exactly one per accepted request
i_imem_rsp_data  in  INS_WIDTH  fetched instruction
i_imem_rsp_err  in  1  access fault on this response
i_redirect  in  1  flush and restart fetch at i_redirect_pc
i_redirect_pc  in  CPU_WIDTH  redirect target
o_ins_valid  out  1  o_ins/o_pc valid for decoder
i_ins_ready  in  1  decoder accepts instruction
o_ins  out  INS_WIDTH  instruction to decoder
o_pc  out  CPU_WIDTH  PC of o_ins
o_ins_err  out  1  fetch fault flag travelling with o_ins

Behaviour:
- Reset (i_rst_n=0 at rising edge):
  - pc=RESET_PC, state=S_REQ, drop=0.
  - o_ins_valid=0, o_ins=0, o_pc=RESET_PC, o_ins_err=0.
  - o_imem_req_valid is forced 0 while i_rst_n=0.
  - Reset mid-transaction abandons the transaction. The memory side must also be reset.
- Outputs:
  - o_imem_req_valid = (state==S_REQ) & i_rst_n.
  - o_imem_addr = {pc[CPU_WIDTH-1:2],2'b00}.
  - o_ins_valid = (state==S_HOLD).
  - o_ins, o_pc, o_ins_err are registered.
- Redirect:
  - The captured target is {i_redirect_pc[CPU_WIDTH-1:2],2'b00}.
  - Low-bit misalignment is ignored here; alignment faults are raised by the PC unit.
- S_REQ:
  - req_valid & req_ready -> S_WAIT.
  - If i_redirect is also high in that cycle: pc<=target, drop<=1.
  - i_redirect without handshake -> pc<=target, stay S_REQ. The address may change because nothing was accepted.
- S_WAIT:
  - Wait for i_imem_rsp_valid. No timeout.
  - rsp_valid & (drop | i_redirect): discard the response, drop<=0, pc<=target if i_redirect, -> S_REQ.
  - rsp_valid otherwise: o_ins<=rsp_data, o_pc<=pc, o_ins_err<=rsp_err, pc<=pc+4, -> S_HOLD.
  - PC increment wraps modulo 2^CPU_WIDTH.
  - i_redirect without rsp_valid: pc<=target, drop<=1, stay S_WAIT.
- S_HOLD:
  - i_redirect (takes priority over i_ins_ready): pc<=target, -> S_REQ. The held instruction is flushed (o_ins_valid falls next cycle).
  - i_ins_ready without redirect: -> S_REQ. The handshake completes this cycle.
  - o_ins, o_pc, o_ins_err are held stable while o_ins_valid & !i_ins_ready.
- Responses with err=1 are delivered normally with o_ins_err=1. o_ins carries rsp_data unchanged. Fetch continues at pc+4 unless redirected.
- Throughput:
  - One outstanding request.
  - Zero-wait memory (req_ready=1, rsp_valid the cycle after acceptance) and i_ins_ready=1 give one instruction per 3 cycles.
  - Latency from request acceptance to o_ins_valid is 1 cycle after rsp_valid.
- Redirect and drop can never require discarding more than one response.

Test Plan:
- Reset release, zero-wait memory returning 32'h00000013 at every address, i_ins_ready=1 -> fetch addresses 8000_0000, 8000_0004, 8000_0008 in order; o_pc matches each; o_ins=00000013; one delivery per 3 cycles.
- i_imem_req_ready held 0 for 5 cycles -> o_imem_req_valid stays 1 with addr 8000_0000 stable; no o_ins_valid until acceptance plus response.
- i_ins_ready=0 for 4 cycles with an instruction held -> o_ins/o_pc/o_ins_err stable, no new o_imem_req_valid; the next request is to pc+4 only after ready.
- Redirect to 8000_0103 pulsed in S_WAIT, response 32'hDEADBEEF arrives 2 cycles later -> DEADBEEF never appears on o_ins; next request addr 8000_0100; o_pc=8000_0100 on the next delivery.
- Redirect to 8000_0200 in S_HOLD with i_ins_ready=1 in the same cycle -> held instruction flushed; next request addr 8000_0200.
- Response with i_imem_rsp_err=1 at 8000_0004 -> o_ins_err=1, o_pc=8000_0004; next fetch 8000_0008 with o_ins_err=0. Synchronous reset asserted in S_WAIT -> o_ins_valid=0, next request after release at 8000_0000.
